// File: rtl/input_frame_loader_pkg.sv
// Shared types and constants for the input SRAM frame loader.
// Holds the controller state encoding, error codes and layout constants.
package input_frame_loader_pkg;

   localparam int ADDR_W_DEF       = 12;
   localparam int DATA_W_DEF       = 16;
   localparam int MIN_DIM_DEF      = 3;
   localparam int MAX_DIM          = 16;
   localparam int BUSY_TIMEOUT_DEF = 16;

   localparam logic [15:0] TERM_WORD_DEF = 16'h00FF;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_DIM  = 2'b01;
   localparam logic [1:0] ERR_OVF  = 2'b10;
   localparam logic [1:0] ERR_TMO  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR_C   = 3'd1,
      ST_ROWS    = 3'd2,
      ST_TERM    = 3'd3,
      ST_RUN     = 3'd4,
      ST_WAIT_HI = 3'd5,
      ST_WAIT_LO = 3'd6,
      ST_FIN     = 3'd7
   } state_t;

endpackage

// File: rtl/input_frame_loader_write_port.sv
// Registered SRAM write port: address/data/enable launch together on the clock edge.
// The address counter saturates at the top of the SRAM instead of wrapping.
module ldr_write_port #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              i_wr_req,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_at_max,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   output logic              o_wr_en
);

   logic [ADDR_W-1:0] r_addr_cnt;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_wr_en;

   assign o_at_max  = (r_addr_cnt == {ADDR_W{1'b1}});
   assign o_wr_addr = r_wr_addr;
   assign o_wr_data = r_wr_data;
   assign o_wr_en   = r_wr_en;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_addr_cnt <= '0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_en    <= 1'b0;
      end else begin
         r_wr_en <= i_wr_req;
         if (i_wr_req) begin
            r_wr_addr <= r_addr_cnt;
            r_wr_data <= i_wr_data;
            if (!o_at_max) r_addr_cnt <= r_addr_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/input_frame_loader.sv
// Streams host matrices into the DUT input SRAM (nrows, ncols, rows..., terminator),
// then starts the DUT and follows its busy level to completion or fault.
module input_frame_loader
   import input_frame_loader_pkg::*;
#(
   parameter int                ADDR_W       = ADDR_W_DEF,
   parameter int                DATA_W       = DATA_W_DEF,
   parameter logic [DATA_W-1:0] TERM_WORD    = DATA_W'(TERM_WORD_DEF),
   parameter int                MIN_DIM      = MIN_DIM_DEF,
   parameter int                BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              frame_valid,
   output logic              frame_ready,
   input  logic [4:0]        frame_nrows,
   input  logic [4:0]        frame_ncols,
   input  logic              frame_last,
   input  logic              row_valid,
   output logic              row_ready,
   input  logic [DATA_W-1:0] row_data,
   output logic [ADDR_W-1:0] ldr_sram_write_address,
   output logic [DATA_W-1:0] ldr_sram_write_data,
   output logic              ldr_sram_write_enable,
   output logic              dut_run,
   input  logic              dut_busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [2:0]        dbg_state
);

   // Handshake: a header or row word transfers on a rising edge where valid and
   // ready are both high; ready depends only on state, never on valid.
   localparam logic [4:0] MIN_V   = 5'(MIN_DIM);
   localparam logic [4:0] MAX_V   = 5'(MAX_DIM);
   localparam int         TMO_W   = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

   state_t            r_state, w_state_next;
   logic              r_live;
   logic [4:0]        r_nrows, r_ncols, r_row_cnt;
   logic              r_last;
   logic [TMO_W-1:0]  r_tmo_cnt;
   logic              r_error, r_done;
   logic [1:0]        r_err_code;

   logic              w_wr_req, w_wr_term, w_at_max;
   logic [DATA_W-1:0] w_wr_data;
   logic              w_set_err, w_set_done, w_latch_hdr;
   logic [1:0]        w_err_code;
   logic              w_load_rows, w_dec_row, w_clr_tmo, w_inc_tmo;
   logic              w_frame_ready, w_row_ready, w_dut_run;
   logic              w_dims_ok;

   assign w_dims_ok = (frame_nrows >= MIN_V) && (frame_nrows <= MAX_V) &&
                      (frame_ncols >= MIN_V) && (frame_ncols <= MAX_V);

   always_comb begin
      w_state_next  = r_state;
      w_wr_req      = 1'b0;
      w_wr_term     = 1'b0;
      w_wr_data     = '0;
      w_set_err     = 1'b0;
      w_err_code    = ERR_NONE;
      w_set_done    = 1'b0;
      w_latch_hdr   = 1'b0;
      w_load_rows   = 1'b0;
      w_dec_row     = 1'b0;
      w_clr_tmo     = 1'b0;
      w_inc_tmo     = 1'b0;
      w_frame_ready = 1'b0;
      w_row_ready   = 1'b0;
      w_dut_run     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_frame_ready = r_live;
            if (frame_valid && r_live) begin
               w_latch_hdr = 1'b1;
               if (!w_dims_ok) begin
                  w_set_err    = 1'b1;
                  w_err_code   = ERR_DIM;
                  w_state_next = ST_FIN;
               end else begin
                  w_wr_req     = 1'b1;
                  w_wr_data    = {{(DATA_W-5){1'b0}}, frame_nrows};
                  w_state_next = ST_HDR_C;
               end
            end
         end
         ST_HDR_C: begin
            w_wr_req     = 1'b1;
            w_wr_data    = {{(DATA_W-5){1'b0}}, r_ncols};
            w_load_rows  = 1'b1;
            w_state_next = ST_ROWS;
         end
         ST_ROWS: begin
            w_row_ready = 1'b1;
            if (row_valid) begin
               w_wr_req  = 1'b1;
               w_wr_data = row_data;
               w_dec_row = 1'b1;
               if (r_row_cnt == 5'd1) w_state_next = r_last ? ST_TERM : ST_IDLE;
            end
         end
         ST_TERM: begin
            w_wr_req     = 1'b1;
            w_wr_term    = 1'b1;
            w_wr_data    = TERM_WORD;
            w_state_next = ST_RUN;
         end
         ST_RUN: begin
            w_dut_run    = 1'b1;
            w_clr_tmo    = 1'b1;
            w_state_next = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (dut_busy) begin
               w_state_next = ST_WAIT_LO;
            end else if (r_tmo_cnt == TMO_LAST) begin
               w_set_err    = 1'b1;
               w_err_code   = ERR_TMO;
               w_state_next = ST_FIN;
            end else begin
               w_inc_tmo = 1'b1;
            end
         end
         ST_WAIT_LO: begin
            if (!dut_busy) begin
               w_set_done   = 1'b1;
               w_state_next = ST_FIN;
            end
         end
         ST_FIN:  w_state_next = ST_FIN;
         default: w_state_next = ST_IDLE;
      endcase
      // A data/header write at the last address still goes out, then the load stops.
      if (w_wr_req && w_at_max && !w_wr_term) begin
         w_set_err    = 1'b1;
         w_err_code   = ERR_OVF;
         w_state_next = ST_FIN;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_state    <= ST_IDLE;
         r_live     <= 1'b0;
         r_nrows    <= '0;
         r_ncols    <= '0;
         r_last     <= 1'b0;
         r_row_cnt  <= '0;
         r_tmo_cnt  <= '0;
         r_error    <= 1'b0;
         r_err_code <= ERR_NONE;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_live  <= 1'b1;
         if (w_latch_hdr) begin
            r_nrows <= frame_nrows;
            r_ncols <= frame_ncols;
            r_last  <= frame_last;
         end
         if (w_load_rows)     r_row_cnt <= r_nrows;
         else if (w_dec_row)  r_row_cnt <= r_row_cnt - 1'b1;
         if (w_clr_tmo)       r_tmo_cnt <= '0;
         else if (w_inc_tmo)  r_tmo_cnt <= r_tmo_cnt + 1'b1;
         if (w_set_err) begin
            r_error    <= 1'b1;
            r_err_code <= w_err_code;
         end
         if (w_set_done) r_done <= 1'b1;
      end
   end

   ldr_write_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_write_port (
      .clk       (clk),
      .reset_b   (reset_b),
      .i_wr_req  (w_wr_req),
      .i_wr_data (w_wr_data),
      .o_at_max  (w_at_max),
      .o_wr_addr (ldr_sram_write_address),
      .o_wr_data (ldr_sram_write_data),
      .o_wr_en   (ldr_sram_write_enable)
   );

   assign frame_ready = w_frame_ready;
   assign row_ready   = w_row_ready;
   assign dut_run     = w_dut_run;
   assign done        = r_done;
   assign error       = r_error;
   assign err_code    = r_err_code;
   assign dbg_state   = r_state;

endmodule
